// File: rtl/axi_addr_arbiter_n_if.sv
// axi_addr_arbiter_n_if: N-master AXI address-channel bundle.
// slave = arbiter view, master = request-side/environment view.
interface axi_addr_arbiter_n_if #(
  parameter int NUM_M     = 2,
  parameter int MID_BITS  = 4,
  parameter int ID_BITS   = 4,
  parameter int ADDR_BITS = 32,
  parameter int LEN_BITS  = 4,
  parameter int SIZE_BITS = 3
);
  logic [NUM_M*ID_BITS-1:0]   ID_S;
  logic [NUM_M*ADDR_BITS-1:0] ADDR_S;
  logic [NUM_M*LEN_BITS-1:0]  LEN_S;
  logic [NUM_M*SIZE_BITS-1:0] SIZE_S;
  logic [NUM_M*2-1:0]         BURST_S;
  logic [NUM_M-1:0]           VALID_S;
  logic [NUM_M-1:0]           READY_S;

  logic [MID_BITS+ID_BITS-1:0] IDS_M;
  logic [ADDR_BITS-1:0]        ADDR_M;
  logic [LEN_BITS-1:0]         LEN_M;
  logic [SIZE_BITS-1:0]        SIZE_M;
  logic [1:0]                  BURST_M;
  logic                        VALID_M;
  logic                        READY_M;

  logic [NUM_M-1:0] GRANT;
  logic             ERR_DROP;

  modport slave (
    input  ID_S, ADDR_S, LEN_S, SIZE_S,
    input  BURST_S, VALID_S, READY_M,
    output READY_S, IDS_M, ADDR_M, LEN_M,
    output SIZE_M, BURST_M, VALID_M,
    output GRANT, ERR_DROP
  );

  modport master (
    output ID_S, ADDR_S, LEN_S, SIZE_S,
    output BURST_S, VALID_S, READY_M,
    input  READY_S, IDS_M, ADDR_M, LEN_M,
    input  SIZE_M, BURST_M, VALID_M,
    input  GRANT, ERR_DROP
  );
endinterface

// File: rtl/axi_addr_arbiter_n.sv
// axi_addr_arbiter_n: N-master AXI AR/AW arbiter, fixed or round-robin.
// Ports: clk, rst (async active-low), bus (slave modport of the _if).
module axi_addr_arbiter_n #(
  parameter int NUM_M     = 2,
  parameter int MID_BITS  = 4,
  parameter int ID_BITS   = 4,
  parameter int ADDR_BITS = 32,
  parameter int LEN_BITS  = 4,
  parameter int SIZE_BITS = 3,
  parameter int RR_MODE   = 1
) (
  input logic clk,
  input logic rst,
  axi_addr_arbiter_n_if.slave bus
);
  localparam int IW = (NUM_M > 1) ? $clog2(NUM_M) : 1;

  typedef enum logic {IDLE, LOCK} st_t;

  st_t           state;
  logic [IW-1:0] lock_q;
  logic [IW-1:0] rr_q;
  logic          err_q;

  logic          found;
  logic [IW-1:0] win;
  logic [IW-1:0] g;
  logic          act;
  logic [NUM_M-1:0] gnt;

  // Winner search; round-robin starts one past the last served master.
  always_comb begin
    int idx;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    if (RR_MODE != 0) begin
      for (int k = 1; k <= NUM_M; k++) begin
        idx = int'(rr_q) + k;
        if (idx >= NUM_M) idx = idx - NUM_M;
        if (!found && bus.VALID_S[IW'(idx)]) begin
          found = 1'b1;
          win   = IW'(idx);
        end
      end
    end else begin
      for (int i = 0; i < NUM_M; i++) begin
        if (bus.VALID_S[i]) begin
          found = 1'b1;
          win   = IW'(i);
        end
      end
    end
  end

  // Reset gates the datapath so nothing leaks out while rst is low.
  always_comb begin
    g   = (state == LOCK) ? lock_q : win;
    act = rst && ((state == LOCK) || found);
    gnt = '0;
    gnt[g] = 1'b1;
  end

  always_comb begin
    bus.GRANT   = '0;
    bus.IDS_M   = '0;
    bus.ADDR_M  = '0;
    bus.LEN_M   = '0;
    bus.SIZE_M  = '0;
    bus.BURST_M = '0;
    bus.VALID_M = 1'b0;
    bus.READY_S = '0;
    if (act) begin
      bus.GRANT   = gnt;
      bus.IDS_M   = {MID_BITS'(gnt),
                     bus.ID_S[g*ID_BITS +: ID_BITS]};
      bus.ADDR_M  = bus.ADDR_S[g*ADDR_BITS +: ADDR_BITS];
      bus.LEN_M   = bus.LEN_S[g*LEN_BITS +: LEN_BITS];
      bus.SIZE_M  = bus.SIZE_S[g*SIZE_BITS +: SIZE_BITS];
      bus.BURST_M = bus.BURST_S[g*2 +: 2];
      bus.VALID_M = bus.VALID_S[g];
      bus.READY_S[g] = bus.VALID_S[g] & bus.READY_M;
    end
  end

  assign bus.ERR_DROP = err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      lock_q <= '0;
      rr_q   <= IW'(NUM_M - 1);
      err_q  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (found) begin
            if (bus.READY_M) begin
              rr_q <= win;
            end else begin
              state  <= LOCK;
              lock_q <= win;
            end
          end
        end
        LOCK: begin
          if (!bus.VALID_S[lock_q]) begin
            err_q <= 1'b1;
            state <= IDLE;
          end else if (bus.READY_M) begin
            rr_q  <= lock_q;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_addr_arbiter_n.sv
// tb_axi_addr_arbiter_n: directed checks of the N-master arbiter.
// Instances: 2-master RR, 4-master RR, 4-master fixed priority.
module tb_axi_addr_arbiter_n;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  axi_addr_arbiter_n_if #(.NUM_M(2)) i2 ();
  axi_addr_arbiter_n_if #(.NUM_M(4)) i4 ();
  axi_addr_arbiter_n_if #(.NUM_M(4)) i4f ();

  axi_addr_arbiter_n #(.NUM_M(2), .RR_MODE(1)) u2 (
    .clk(clk), .rst(rst), .bus(i2)
  );
  axi_addr_arbiter_n #(.NUM_M(4), .RR_MODE(1)) u4 (
    .clk(clk), .rst(rst), .bus(i4)
  );
  axi_addr_arbiter_n #(.NUM_M(4), .RR_MODE(0)) u4f (
    .clk(clk), .rst(rst), .bus(i4f)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;

    i2.ID_S    = {4'h3, 4'h5};
    i2.ADDR_S  = {32'h0001_0040, 32'h0000_1000};
    i2.LEN_S   = {4'h7, 4'h1};
    i2.SIZE_S  = {3'd2, 3'd3};
    i2.BURST_S = {2'b01, 2'b10};
    i2.VALID_S = 2'b11;
    i2.READY_M = 1'b0;

    i4.ID_S    = {4'hd, 4'hc, 4'hb, 4'ha};
    i4.ADDR_S  = {32'h300, 32'h200, 32'h100, 32'h000};
    i4.LEN_S   = '0;
    i4.SIZE_S  = '0;
    i4.BURST_S = '0;
    i4.VALID_S = 4'b0000;
    i4.READY_M = 1'b0;

    i4f.ID_S    = {4'hd, 4'hc, 4'hb, 4'ha};
    i4f.ADDR_S  = {32'h300, 32'h200, 32'h100, 32'h000};
    i4f.LEN_S   = '0;
    i4f.SIZE_S  = '0;
    i4f.BURST_S = '0;
    i4f.VALID_S = 4'b0000;
    i4f.READY_M = 1'b0;

    // Reset held 3 cycles with both masters requesting.
    repeat (3) cyc();
    chk("rst_grant", 64'(i2.GRANT), 64'h0);
    chk("rst_err", 64'(i2.ERR_DROP), 64'h0);
    chk("rst_ready", 64'(i2.READY_S), 64'h0);
    chk("rst_valid", 64'(i2.VALID_M), 64'h0);

    // First grant after reset wraps rr_ptr=1 to master 0.
    rst = 1'b1;
    i2.READY_M = 1'b1;
    #2;
    chk("first_grant", 64'(i2.GRANT), 64'h1);
    chk("first_ids", 64'(i2.IDS_M), 64'h15);
    chk("first_ready", 64'(i2.READY_S), 64'h1);
    chk("first_burst", 64'(i2.BURST_M), 64'h2);
    cyc();

    // Same-cycle handshake for master 1.
    i2.VALID_S = 2'b10;
    #2;
    chk("sc_ids", 64'(i2.IDS_M), 64'h23);
    chk("sc_ready", 64'(i2.READY_S), 64'h2);
    chk("sc_addr", 64'(i2.ADDR_M), 64'h0001_0040);
    chk("sc_len", 64'(i2.LEN_M), 64'h7);
    chk("sc_size", 64'(i2.SIZE_M), 64'h2);
    cyc();

    // Lock hold: master 0 waits, master 1 joins in cycle 2.
    i2.VALID_S = 2'b01;
    i2.READY_M = 1'b0;
    #2;
    chk("lk1_grant", 64'(i2.GRANT), 64'h1);
    chk("lk1_ready", 64'(i2.READY_S), 64'h0);
    cyc();
    i2.VALID_S = 2'b11;
    #2;
    chk("lk2_grant", 64'(i2.GRANT), 64'h1);
    chk("lk2_addr", 64'(i2.ADDR_M), 64'h1000);
    chk("lk2_ready", 64'(i2.READY_S), 64'h0);
    cyc();
    #2;
    chk("lk3_grant", 64'(i2.GRANT), 64'h1);
    cyc();
    #2;
    chk("lk4_grant", 64'(i2.GRANT), 64'h1);
    chk("lk4_addr", 64'(i2.ADDR_M), 64'h1000);
    cyc();
    i2.READY_M = 1'b1;
    #2;
    chk("lk5_ready", 64'(i2.READY_S), 64'h1);
    chk("lk5_grant", 64'(i2.GRANT), 64'h1);
    cyc();
    #2;
    chk("lk6_grant", 64'(i2.GRANT), 64'h2);
    chk("lk6_ready", 64'(i2.READY_S), 64'h2);
    cyc();

    // Idle with nothing requesting: every output is 0.
    i2.VALID_S = 2'b00;
    i2.READY_M = 1'b0;
    #2;
    chk("idle_grant", 64'(i2.GRANT), 64'h0);
    chk("idle_addr", 64'(i2.ADDR_M), 64'h0);
    chk("idle_ids", 64'(i2.IDS_M), 64'h0);
    chk("idle_valid", 64'(i2.VALID_M), 64'h0);
    cyc();

    // Round-robin 0,1,2,3,0 vs fixed priority always 3.
    i4.VALID_S  = 4'b1111;
    i4.READY_M  = 1'b1;
    i4f.VALID_S = 4'b1111;
    i4f.READY_M = 1'b1;
    #2;
    chk("rr0_grant", 64'(i4.GRANT), 64'h1);
    chk("fx0_grant", 64'(i4f.GRANT), 64'h8);
    cyc();
    #2;
    chk("rr1_grant", 64'(i4.GRANT), 64'h2);
    chk("rr1_addr", 64'(i4.ADDR_M), 64'h100);
    chk("fx1_grant", 64'(i4f.GRANT), 64'h8);
    cyc();
    #2;
    chk("rr2_grant", 64'(i4.GRANT), 64'h4);
    chk("rr2_ids", 64'(i4.IDS_M), 64'h4c);
    chk("fx2_grant", 64'(i4f.GRANT), 64'h8);
    cyc();
    #2;
    chk("rr3_grant", 64'(i4.GRANT), 64'h8);
    chk("rr3_ready", 64'(i4.READY_S), 64'h8);
    chk("fx3_ids", 64'(i4f.IDS_M), 64'h8d);
    cyc();
    #2;
    chk("rr4_grant", 64'(i4.GRANT), 64'h1);
    chk("fx4_grant", 64'(i4f.GRANT), 64'h8);
    cyc();

    // Valid drop: master 2 locks, then withdraws.
    i4f.VALID_S = 4'b0000;
    i4.VALID_S  = 4'b0100;
    i4.READY_M  = 1'b0;
    #2;
    chk("vd_grant", 64'(i4.GRANT), 64'h4);
    cyc();
    i4.VALID_S = 4'b1000;
    #2;
    chk("vd_hold", 64'(i4.GRANT), 64'h4);
    chk("vd_validm", 64'(i4.VALID_M), 64'h0);
    chk("vd_err0", 64'(i4.ERR_DROP), 64'h0);
    cyc();
    i4.READY_M = 1'b1;
    #2;
    chk("vd_err1", 64'(i4.ERR_DROP), 64'h1);
    chk("vd_next", 64'(i4.GRANT), 64'h8);
    chk("vd_ready", 64'(i4.READY_S), 64'h8);
    cyc();
    i4.VALID_S = 4'b0000;
    cyc();
    #2;
    chk("vd_sticky", 64'(i4.ERR_DROP), 64'h1);

    // Async reset mid-lock on the 2-master instance.
    i2.VALID_S = 2'b01;
    i2.READY_M = 1'b0;
    cyc();
    #2;
    chk("ar_locked", 64'(i2.GRANT), 64'h1);
    i2.READY_M = 1'b1;
    rst = 1'b0;
    #1;
    chk("ar_grant", 64'(i2.GRANT), 64'h0);
    chk("ar_ready", 64'(i2.READY_S), 64'h0);
    chk("ar_err4", 64'(i4.ERR_DROP), 64'h0);
    cyc();
    chk("ar_ready2", 64'(i2.READY_S), 64'h0);

    // Back out of reset: lock gone, master 1 alone wins at once.
    i2.VALID_S = 2'b10;
    i2.READY_M = 1'b0;
    rst = 1'b1;
    #2;
    chk("ar_idle", 64'(i2.GRANT), 64'h2);
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
